// File: rtl/biu_arb_if.sv
// biu_arb_if: ICB-style command/response bundle shared by IFU, LSU and memory ports
interface biu_arb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [ADDR_WIDTH-1:0]   cmd_addr;
   logic                    cmd_read;
   logic [DATA_WIDTH-1:0]   cmd_wdata;
   logic [DATA_WIDTH/8-1:0] cmd_wmask;
   logic                    rsp_valid;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_err;

   modport master (
      output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/biu_arb.sv
// biu_arb: IFU/LSU arbiter onto one ICB port with in-order response routing; BIU_ARB_RR_EN selects round-robin
module biu_arb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int OST_DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   biu_arb_if.slave                    ifu,
   biu_arb_if.slave                    lsu,
   biu_arb_if.master                   mem,
   output logic                        mem_rsp_ready,
   output logic [$clog2(OST_DEPTH):0]  arb_ost_cnt,
   output logic                        arb_orphan_err
);
   localparam int PW = $clog2(OST_DEPTH);

   logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]          cnt_q, cnt_d;
   logic [OST_DEPTH-1:0] src_q, src_d;
   logic                 orphan_q, orphan_d;
   logic                 act_q;
   logic                 full, gnt_lsu, gnt_ifu, push, pop, rsp_hit;
`ifdef BIU_ARB_RR_EN
   logic                 last_q, last_d;
`endif

   always_comb begin
      full = cnt_q == (PW+1)'(OST_DEPTH);
`ifdef BIU_ARB_RR_EN
      // last_q holds the previous winner; the other side has priority now
      gnt_lsu = lsu.cmd_valid & (~ifu.cmd_valid | ~last_q);
`else
      gnt_lsu = lsu.cmd_valid;
`endif
      gnt_ifu = ifu.cmd_valid & ~gnt_lsu;
      mem.cmd_valid = act_q & ~full & (ifu.cmd_valid | lsu.cmd_valid);
      mem.cmd_addr  = gnt_lsu ? lsu.cmd_addr  : ifu.cmd_addr;
      mem.cmd_read  = gnt_lsu ? lsu.cmd_read  : 1'b1;
      mem.cmd_wdata = gnt_lsu ? lsu.cmd_wdata : '0;
      mem.cmd_wmask = gnt_lsu ? lsu.cmd_wmask : '1;
      lsu.cmd_ready = gnt_lsu & act_q & ~full & mem.cmd_ready;
      ifu.cmd_ready = gnt_ifu & act_q & ~full & mem.cmd_ready;
      push    = mem.cmd_valid & mem.cmd_ready;
      rsp_hit = act_q & mem.rsp_valid;
      pop     = rsp_hit & (cnt_q != '0);
      ifu.rsp_valid = pop & ~src_q[rptr_q];
      lsu.rsp_valid = pop & src_q[rptr_q];
      ifu.rsp_rdata = mem.rsp_rdata;
      lsu.rsp_rdata = mem.rsp_rdata;
      ifu.rsp_err   = mem.rsp_err;
      lsu.rsp_err   = mem.rsp_err;
      src_d = src_q;
      src_d[wptr_q] = push ? gnt_lsu : src_q[wptr_q];
      wptr_d   = wptr_q + PW'(push);
      rptr_d   = rptr_q + PW'(pop);
      cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      orphan_d = orphan_q | (rsp_hit & (cnt_q == '0));
`ifdef BIU_ARB_RR_EN
      last_d = push ? gnt_lsu : last_q;
`endif
   end

   // act_q keeps every handshake output low while reset is applied
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         src_q    <= '0;
         orphan_q <= 1'b0;
         act_q    <= 1'b0;
`ifdef BIU_ARB_RR_EN
         last_q   <= 1'b0;
`endif
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         src_q    <= src_d;
         orphan_q <= orphan_d;
         act_q    <= 1'b1;
`ifdef BIU_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   assign mem_rsp_ready  = act_q;
   assign arb_ost_cnt    = cnt_q;
   assign arb_orphan_err = orphan_q;
endmodule
